// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the 5-stage pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int MEM_TIMEOUT_DEF = 16;

  // A producer only matches when it really writes a non-x0 register.
  function automatic logic reg_match(input logic [4:0] rd, input logic we,
                                     input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand-forwarding selector for one EX operand.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output fwd_sel_t   fwd_sel
);

  // The younger EX/MEM result shadows the older MEM/WB one.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_match(mem_rd, mem_reg_write, ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_match(wb_rd, wb_reg_write, ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the in-order RV32I pipeline.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_loaduse
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  // The RUN cycle that raised the request already stalled once, so the
  // release lands after MEM_TIMEOUT-1 stall cycles.
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 2);

  hctrl_state_t    state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic     timeout_now, mstall, load_use, branch_go, lu_bubble;
  fwd_sel_t fwd_a_sel, fwd_b_sel;

  assign timeout_now = (state_q == MEM_WAIT) && (wait_cnt_q == WC_LAST);
  assign mstall      = dmem_req && !dmem_ready && !timeout_now;
  assign load_use    = ex_is_load &&
                       ((id_use_rs1 && reg_match(ex_rd, ex_reg_write, id_rs1)) ||
                        (id_use_rs2 && reg_match(ex_rd, ex_reg_write, id_rs2)));
  assign branch_go   = ex_branch_taken && !mstall;
  assign lu_bubble   = load_use && !branch_go && !mstall;

  hazard_fwd_unit u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .fwd_sel      (fwd_a_sel)
  );

  hazard_fwd_unit u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .fwd_sel      (fwd_b_sel)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = timeout_now && dmem_req && !dmem_ready;
    case (state_q)
      RUN: begin
        if (mstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mstall) begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Priority: reset, memory stall, taken branch, load-use bubble.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mstall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_go) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (lu_bubble) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  assign fwd_a   = rst ? 2'b00 : fwd_a_sel;
  assign fwd_b   = rst ? 2'b00 : fwd_b_sel;
  assign mem_err = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
  logic [CNT_W-1:0] perf_loaduse_q, perf_loaduse_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic ev);
    return (ev && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    perf_stall_d   = sat_inc(perf_stall_q, mstall);
    perf_flush_d   = sat_inc(perf_flush_q, branch_go);
    perf_loaduse_d = sat_inc(perf_loaduse_q, lu_bubble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
      perf_loaduse_q <= '0;
    end else begin
      perf_stall_q   <= perf_stall_d;
      perf_flush_q   <= perf_flush_d;
      perf_loaduse_q <= perf_loaduse_d;
    end
  end

  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
  assign perf_loaduse = perf_loaduse_q;
`else
  assign perf_stall   = '0;
  assign perf_flush   = '0;
  assign perf_loaduse = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MT    = 4;
  localparam int CNT_W = 32;
  localparam logic [11:0] RST_VEC = 12'b0000_111_00_00_0;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
  logic id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load, mem_reg_write, wb_reg_write;
  logic ex_branch_taken, dmem_req, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] perf_stall, perf_flush, perf_loaduse;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_loaduse(perf_loaduse)
  );

  always #5 clk = ~clk;

  logic [11:0] obs;
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
                memwb_bubble, fwd_a, fwd_b, mem_err};

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: stall cycles spent on the current access, pending error, counters.
  int m_prior = 0;
  logic m_err = 1'b0;
  logic [CNT_W-1:0] m_pstall = '0, m_pflush = '0, m_plu = '0;
  logic e_stall, e_tmo, e_br, e_lu;
  logic [11:0] exp_v;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] perf_exp(input logic [CNT_W-1:0] v);
`ifdef PIPE_HAZARD_PERF_EN
    return v;
`else
    return (v & '0);
`endif
  endfunction

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic model_reset();
    m_prior = 0; m_err = 1'b0; m_pstall = '0; m_pflush = '0; m_plu = '0;
  endtask

  // Derive this cycle's expected outputs from the current inputs, then move to the sample point.
  task automatic eval_model();
    logic lu;
    e_stall = dmem_req && !dmem_ready && (m_prior < MT - 1);
    e_tmo   = dmem_req && !dmem_ready && !e_stall;
    lu = ex_is_load && ex_reg_write && ex_rd != 0 &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    e_br = ex_branch_taken && !e_stall;
    e_lu = lu && !e_br && !e_stall;
    exp_v = {!e_stall && !e_lu, !e_stall && !e_lu, !e_stall, !e_stall,
             e_br, e_br || e_lu, e_stall, fwd_ref(ex_rs1), fwd_ref(ex_rs2), m_err};
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_err   = e_tmo;
    m_prior = e_stall ? m_prior + 1 : 0;
    if (e_stall) m_pstall++;
    if (e_br)    m_pflush++;
    if (e_lu)    m_plu++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    dmem_req = 1'b1;
    ex_branch_taken = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== RST_VEC) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want %b", obs, RST_VEC);
    end
    tests_run++;
    if ({perf_stall, perf_flush, perf_loaduse} !== '0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_stall, perf_flush, perf_loaduse);
    end
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    set_idle();
    dmem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      eval_model();
      if (memwb_bubble && !pc_en && !exmem_en) stalls++;
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL timeout_cyc%0d: got %b want %b", c, obs, exp_v);
      end
      advance();
    end
    dmem_req = 1'b0;
    eval_model();
    tests_run++;
    if (stalls !== MT - 1 || mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_release: stalls %0d err %b want %0d err 1", stalls, mem_err, MT - 1);
    end
    tests_run++;
    if (perf_stall !== perf_exp(CNT_W'(MT - 1))) begin
      tests_failed++;
      $display("FAIL timeout_perf_stall: got %0d want %0d", perf_stall, perf_exp(CNT_W'(MT - 1)));
    end
    advance();
    eval_model();
    tests_run++;
    if (obs !== exp_v || mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_err_pulse: got %b want %b", obs, exp_v);
    end
    advance();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_rd = 5; ex_is_load = 1; ex_reg_write = 1; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 7;
    eval_model();
    tests_run++;
    if (obs !== exp_v || pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_flush !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_bubble: got %b want %b", obs, exp_v);
    end
    advance();
    // Load now in WB, dependent add in EX behind the bubble.
    set_idle();
    wb_rd = 5; wb_reg_write = 1; ex_rs1 = 5; id_rs1 = 9;
    eval_model();
    tests_run++;
    if (obs !== exp_v || fwd_a !== 2'b01 || {pc_en, ifid_en, idex_en, exmem_en} !== 4'hF) begin
      tests_failed++;
      $display("FAIL load_use_after: got %b want %b", obs, exp_v);
    end
    advance();
    set_idle();
    ex_rd = 0; ex_is_load = 1; ex_reg_write = 1; id_use_rs2 = 1;
    eval_model();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL load_use_x0: got %b want %b", obs, exp_v);
    end
    advance();
  endtask

  task automatic test_forwarding();
    set_idle();
    mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1; ex_rs1 = 3; ex_rs2 = 3;
    eval_model();
    tests_run++;
    if (obs !== exp_v || fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      tests_failed++;
      $display("FAIL fwd_mem_priority: got %b want %b", obs, exp_v);
    end
    advance();
    set_idle();
    mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1; ex_rs1 = 0; ex_rs2 = 0;
    eval_model();
    tests_run++;
    if (obs !== exp_v || fwd_a !== 2'b00) begin
      tests_failed++;
      $display("FAIL fwd_x0: got %b want %b", obs, exp_v);
    end
    advance();
    for (int i = 0; i < 24; i++) begin
      set_idle();
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      eval_model();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL fwd_rand%0d: got %b want %b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    set_idle();
    ex_branch_taken = 1; ex_rd = 4; ex_is_load = 1; ex_reg_write = 1; id_rs2 = 4; id_use_rs2 = 1;
    eval_model();
    tests_run++;
    if (obs !== exp_v || pc_en !== 1'b1 || ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_over_load_use: got %b want %b", obs, exp_v);
    end
    advance();
    // A branch during a memory stall is held, then flushes on release.
    set_idle();
    ex_branch_taken = 1; dmem_req = 1;
    for (int c = 0; c < 3; c++) begin
      dmem_ready = (c == 2);
      eval_model();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL branch_in_stall%0d: got %b want %b", c, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_mem_wait();
    int stalls = 0;
    set_idle();
    dmem_req = 1;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      eval_model();
      if (!pc_en && !ifid_en && !idex_en && !exmem_en && memwb_bubble) stalls++;
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL mem_wait_cyc%0d: got %b want %b", c, obs, exp_v);
      end
      advance();
    end
    set_idle();
    eval_model();
    tests_run++;
    if (stalls !== 3 || obs !== exp_v || mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_wait_count: stalls %0d obs %b want 3 / %b", stalls, obs, exp_v);
    end
    advance();
    dmem_req = 1; dmem_ready = 1;
    eval_model();
    tests_run++;
    if (obs !== exp_v || pc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL mem_ready_same_cycle: got %b want %b", obs, exp_v);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3)); ex_reg_write = 1'($urandom); ex_is_load = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      dmem_req = ($urandom_range(0, 9) < 6);
      dmem_ready = ($urandom_range(0, 9) < 3);
      eval_model();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL random%0d: got %b want %b", i, obs, exp_v);
      end
      advance();
    end
    set_idle();
    @(negedge clk);
    tests_run++;
    if (perf_stall !== perf_exp(m_pstall) || perf_flush !== perf_exp(m_pflush) ||
        perf_loaduse !== perf_exp(m_plu)) begin
      tests_failed++;
      $display("FAIL perf_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
               perf_stall, perf_flush, perf_loaduse,
               perf_exp(m_pstall), perf_exp(m_pflush), perf_exp(m_plu));
    end
    @(posedge clk);
    #1;
    m_err = 1'b0;
    m_prior = 0;
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    dmem_req = 1;
    for (int c = 0; c < 2; c++) begin
      eval_model();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL rstwait_pre%0d: got %b want %b", c, obs, exp_v);
      end
      advance();
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== RST_VEC || {perf_stall, perf_flush, perf_loaduse} !== '0) begin
      tests_failed++;
      $display("FAIL rstwait_async: got %b want %b", obs, RST_VEC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    // Full wait after reset must again allow MT-1 stalls and then one error pulse.
    for (int c = 0; c < 6; c++) begin
      dmem_req = (c < 4);
      eval_model();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL rstwait_post%0d: got %b want %b", c, obs, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_timeout();
    test_load_use();
    test_forwarding();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
